// File: rtl/reload_sequencer.sv
// reload_sequencer: queues host reload values and feeds one counter load per terminal count event
module reload_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] TERM_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       wr_ready_o,
    input  logic [WIDTH-1:0]           count_i,
    output logic                       load_o,
    output logic [WIDTH-1:0]           load_val_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       underrun_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] count_q;
    logic             push, pop, term_hit, underrun_n;

    assign empty_o    = level_o == '0;
    assign full_o     = level_o == LW'(DEPTH);
    assign wr_ready_o = !full_o;
    assign push       = wr_valid_i && !full_o;
    assign term_hit   = (count_i == TERM_VAL) && (count_q != TERM_VAL);

    // next state: pop the head whenever we enter LOAD, flag underrun on a terminal event with nothing queued
    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        underrun_n = 1'b0;
        case (state)
            IDLE: begin
                pop     = !empty_o;
                state_n = empty_o ? IDLE : LOAD;
            end
            LOAD: state_n = ARMED;
            ARMED: begin
                pop        = term_hit && !empty_o;
                underrun_n = term_hit && empty_o;
                state_n    = !term_hit ? ARMED : empty_o ? IDLE : LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO storage needs no reset; validity is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data_i;
    end

    // FSM, FIFO pointers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= TERM_VAL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            load_o     <= 1'b0;
            load_val_o <= '0;
            underrun_o <= 1'b0;
        end else begin
            state      <= state_n;
            count_q    <= count_i;
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            level_o    <= level_o + LW'(push) - LW'(pop);
            load_o     <= pop;
            load_val_o <= pop ? mem[rd_ptr] : load_val_o;
            underrun_o <= underrun_n;
        end
    end
endmodule

// File: tb/tb_reload_sequencer.sv
// tb_reload_sequencer: directed scenarios plus random traffic checked against a queue-based model
module tb_reload_sequencer;
    logic       clk = 0, reset = 1;
    logic       wr_valid = 0;
    logic [3:0] wr_data = 0, count = 0;
    logic       wr_ready, load, empty, full, underrun;
    logic [3:0] load_val;
    logic [2:0] level;

    reload_sequencer dut (
        .clk(clk), .reset(reset), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready), .count_i(count), .load_o(load), .load_val_o(load_val),
        .level_o(level), .empty_o(empty), .full_o(full), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int q[$];
    int phase;
    int prev;
    bit m_load, m_under;
    int m_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase = 0;
        prev = 0;
        m_load = 0;
        m_val = 0;
        m_under = 0;
    endtask

    // phase: 0 = waiting for data, 1 = strobing a load, 2 = waiting for the end of the period
    task automatic model_edge();
        bit term, push, take;
        if (reset) begin
            model_reset();
            return;
        end
        term = phase == 2 && count == 0 && prev != 0;
        push = wr_valid && q.size() < 4;
        take = q.size() > 0 && (phase == 0 || term);
        m_under = term && q.size() == 0;
        m_load = take;
        if (take) m_val = q.pop_front();
        if (push) q.push_back(int'(wr_data));
        phase = take ? 1 : phase == 1 ? 2 : m_under ? 0 : phase;
        prev = int'(count);
    endtask

    task automatic compare_all();
        check("load_o", load, m_load);
        check("load_val_o", load_val, m_val);
        check("underrun_o", underrun, m_under);
        check("level_o", level, q.size());
        check("empty_o", empty, q.size() == 0);
        check("full_o", full, q.size() == 4);
        check("wr_ready_o", wr_ready, q.size() < 4);
    endtask

    task automatic cyc(input logic v, input logic [3:0] d, input logic [3:0] c);
        wr_valid = v;
        wr_data = d;
        count = c;
        @(posedge clk);
        model_edge();
        #1 compare_all();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cyc(0, 0, 3);
        reset = 0;
        for (int i = 0; i < 6; i++) cyc(0, 0, (i % 2) ? 4'd0 : 4'd3);
        cyc(1, 4'h5, 3);
        cyc(0, 0, 3);
        check("strobe_val5", load_val, 5);
        cyc(0, 0, 3);
        cyc(1, 4'hC, 2);
        cyc(1, 4'h3, 2);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("strobe_valC", load && load_val == 4'hC, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 2);
        cyc(0, 0, 0);
        check("strobe_val3", load && load_val == 4'h3, 1);
        cyc(0, 0, 2);
        for (int i = 0; i < 5; i++) cyc(1, 4'(i + 8), 2);
        check("full_held", full && !wr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("underrun_pulse", underrun, 1);
        cyc(0, 0, 0);
        cyc(1, 4'h7, 0);
        cyc(0, 0, 0);
        check("after_underrun", load && load_val == 4'h7, 1);
        reset = 1;
        cyc(0, 0, 5);
        reset = 0;
        cyc(1, 4'h5, 5);
        cyc(1, 4'h6, 5);
        cyc(1, 4'h7, 5);
        cyc(1, 4'h8, 5);
        cyc(0, 0, 0);
        check("pre_reset_state", load && level == 2, 1);
        #2 reset = 1;
        #1;
        check("rst_load", load, 0);
        check("rst_val", load_val, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_under", underrun, 0);
        model_reset();
        @(negedge clk);
        cyc(0, 0, 0);
        reset = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom_range(0, 3)));
        end
        reset = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
